// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the iterative shift-and-add multiplier.
//   state_t   : controller states (IDLE / RUN / DONE)
//   MAX_WIDTH : largest supported operand width
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/seq_multiplier_add_shift_step.sv
// -----------------------------------------------------------------------------
// add_shift_step
// One combinational iteration of the shift-and-add multiply.
//   acc, mcand  (2*WIDTH) : running sum and shifted multiplicand
//   mplier      (WIDTH)   : remaining multiplier bits, LSB consumed first
//   next_acc, next_mcand, next_mplier : values for the next iteration
// -----------------------------------------------------------------------------
module add_shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] next_acc,
    output logic [2*WIDTH-1:0] next_mcand,
    output logic [WIDTH-1:0]   next_mplier
);

    // mcand is zero-extended to 2*WIDTH, so the sum never overflows.
    assign next_acc    = mplier[0] ? (acc + mcand) : acc;
    assign next_mcand  = mcand << 1;
    assign next_mplier = mplier >> 1;

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one partial product
// per clock, with valid/ready handshakes on both sides.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its data stable while valid
// is high and ready is low. in_ready is high only in IDLE; out_valid is high
// only in DONE, so an accept never coincides with an output transfer.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b       (WIDTH)   : multiplicand, multiplier (sampled at accept)
//   op_signed            : two's-complement operands (SEQ_MULTIPLIER_SIGNED_EN only)
//   out_valid, out_ready : result handshake
//   product  (2*WIDTH)   : registered result, holds last value after transfer
//   busy                 : high in RUN or DONE
//
// Optional build macro: SEQ_MULTIPLIER_SIGNED_EN adds signed multiplication.
// Latency: accept at edge N -> out_valid at edge N+WIDTH.
// -----------------------------------------------------------------------------
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic                 op_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;

    logic [2*WIDTH-1:0]   next_acc;
    logic [2*WIDTH-1:0]   next_mcand;
    logic [WIDTH-1:0]     next_mplier;
    logic [2*WIDTH-1:0]   final_acc;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic neg;

    // Magnitudes of signed operands; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits.
    assign a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign final_acc = neg ? (~next_acc + 1'b1) : next_acc;
`else
    assign a_mag     = a;
    assign b_mag     = b;
    assign final_acc = next_acc;
`endif

    add_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .next_acc    (next_acc),
        .next_mcand  (next_mcand),
        .next_mplier (next_mplier)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                        neg    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    mcand  <= next_mcand;
                    mplier <= next_mplier;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // Last accumulate and sign fix-up land on the same edge.
                        acc       <= final_acc;
                        product   <= final_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= next_acc;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised iterative shift-and-add unsigned multiplier: WIDTH x WIDTH operands -> 2*WIDTH product.
- Successor to our fixed 2-bit combinational multiplier. Adds generic width, a clocked datapath and valid/ready handshakes on input and output.
- Serves as the arithmetic unit behind the CPU's MUL instruction. The issue stage drives the input side; writeback drains the output side.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a/b are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  a*b.
- busy  out  1  high in RUN or DONE.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN: iterate.
  - DONE: out_valid=1.
- Reset (rst_n low, at any time, including mid-RUN or in DONE with out_valid held):
  - state=IDLE, all datapath registers 0, counter 0, product=0, out_valid=0, busy=0.
  - An aborted operation produces no output.
  - No handshake is honoured while rst_n is low.
- IDLE:
  - On in_valid && in_ready at edge N: mcand <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, cnt <= 0, state <= RUN.
  - a and b are sampled only at this edge; later changes are ignored.
- RUN, each cycle:
  - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, never overflows).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == WIDTH-1: state <= DONE. The final accumulate happens on this same edge.
- Latency: out_valid is high from edge N+WIDTH; product == acc, registered.
- DONE:
  - product and out_valid are held stable until out_valid && out_ready.
  - On that edge: state <= IDLE, out_valid <= 0. product keeps its last value.
- out_ready has no effect outside DONE.
- in_ready = (state == IDLE), driven from the state register.
  - No accept in the same cycle as an output transfer.
  - Maximum throughput: one result per WIDTH+2 cycles.
- Boundaries:
  - a=0 or b=0 -> product 0, still WIDTH cycles; no early exit.
  - All-ones operands -> (2^WIDTH-1)^2 with no truncation.
- Counter: must reach WIDTH-1 without wrapping; CNT_W guarantees this.

Optional Feature:
- Macro: SEQ_MULTIPLIER_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), sampled at accept.
  - When op_signed=1, a and b are two's complement. At accept the block stores their magnitudes and neg = a[MSB] ^ b[MSB].
  - On the RUN->DONE edge the block negates acc (two's complement, 2*WIDTH bits) if neg=1.
  - Latency unchanged.
  - Most-negative operands are handled: -2^(WIDTH-1) squared = 2^(2*WIDTH-2).
  - When op_signed=0, behaviour is identical to the undefined case.
- Undefined: no op_signed port; unsigned only.

Decomposition:
- Package seq_mul_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam MAX_WIDTH=32.
- Sub-module add_shift_step (combinational, parameter WIDTH):
  - inputs acc, mcand, mplier.
  - outputs next_acc, next_mcand, next_mplier.
  - The top level holds the FSM, counter and registers and instantiates one add_shift_step.

Test Plan:
- WIDTH=2, a=3, b=1, out_ready=1: product=4'b0011; out_valid rises exactly 2 cycles after the accept edge; in_ready=0 until the cycle after the transfer.
- WIDTH=8, a=255, b=255: product=16'hFE01. Also a=0, b=200 -> 16'h0000, still with 8-cycle latency.
- Backpressure, WIDTH=8, a=12, b=10, out_ready=0 for 5 cycles after out_valid: product=16'h0078 held stable; in_valid high meanwhile is not accepted; transfer occurs on the first out_ready=1 edge.
- Reset mid-RUN: pulse rst_n low at cycle 3 of an operation. All outputs go to 0 immediately (asynchronous), no out_valid afterwards, in_ready=1 after release. A following 7*6 yields 16'h002A.
- Back-to-back: 10 random operand pairs with random out_ready. Every product matches a golden a*b in order; no drops and no duplicates.
- SEQ_MULTIPLIER_SIGNED_EN, WIDTH=8, op_signed=1:
  - -3*5 -> 16'hFFF1.
  - -128*-128 -> 16'h4000.
  - op_signed=0 with a=8'hFD, b=5 -> 16'h04F1.
